mdu_sequencer: RTL and testbench

Multi-cycle controller that sequences an iterative RV32M multiply/divide unit next to the core's single-cycle ALU. The decoder routes funct7=0000001 OP instructions here instead of the ALU. `busy_o` stalls PC/register-file write-back until the result is ready. One shift-add or restore-subtract step runs per cycle under an FSM, so the divider and the 2·WIDTH-bit product register are shared across all eight M operations.

---
 rtl/mdu_pkg.sv | 40 ++++
 rtl/mdu_step.sv | 34 +++
 rtl/mdu_sequencer.sv | 146 ++++++++++++++
 tb/tb_mdu_sequencer.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings for the RV32M multiply/divide sequencer
package mdu_pkg;

  // M-extension funct7; the decoder also uses it to route OP instructions here
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // funct3 encodings of the eight M operations
  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } mdu_state_t;

  // funct3[2] separates the divide group from the multiply group
  function automatic logic op_is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM
  function automatic logic rs1_is_signed(input logic [2:0] f3);
    return (f3 == MDU_MULH) || (f3 == MDU_MULHSU) || (f3 == MDU_DIV) || (f3 == MDU_REM);
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM
  function automatic logic rs2_is_signed(input logic [2:0] f3);
    return (f3 == MDU_MULH) || (f3 == MDU_DIV) || (f3 == MDU_REM);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// rtl/mdu_step.sv - one combinational add-shift or restore-subtract iteration
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH:0]   acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH:0]   next_acc
);

  logic [WIDTH:0]   sum;
  logic [2*WIDTH:0] mul_next;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;
  logic [2*WIDTH:0] div_next;

  // Multiply: upper half (with carry) gains the multiplicand when the current
  // multiplier bit is set, then the whole accumulator shifts right by one
  assign sum      = acc[0] ? (acc[2*WIDTH:WIDTH] + {1'b0, operand}) : acc[2*WIDTH:WIDTH];
  assign mul_next = {1'b0, sum, acc[WIDTH-1:1]};

  // Divide: shift the partial remainder left, bringing in the next dividend bit,
  // trial-subtract the divisor and keep the difference only when it is non-negative
  assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign diff     = {1'b0, rem_sh} - {2'b00, operand};
  assign div_next = diff[WIDTH+1] ? {rem_sh, acc[WIDTH-2:0], 1'b0}
                                  : {diff[WIDTH:0], acc[WIDTH-2:0], 1'b1};

  // Select the iteration flavour for the current operation
  always_comb begin
    next_acc = is_div ? div_next : mul_next;
  end

endmodule

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - multi-cycle RV32M multiply/divide sequencer FSM
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [2:0]       funct3_i,
  input  logic [WIDTH-1:0] rs1_data_i,
  input  logic [WIDTH-1:0] rs2_data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mdu_state_t       state;
  logic [2:0]       f3;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [WIDTH-1:0] operand_r;
  logic [2*WIDTH:0] acc;
  logic [CW-1:0]    cnt;
  logic             neg_q;
  logic             neg_r;

  logic             is_div;
  logic             neg1;
  logic             neg2;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic [2*WIDTH:0] step_acc;
  logic [WIDTH-1:0] step_operand;
  logic [2*WIDTH:0] step_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] fix_result;

  // Operand signs/magnitudes and the step input; PREP runs the first iteration
  // straight from the magnitudes so RUN only needs WIDTH-1 further cycles
  always_comb begin
    is_div = op_is_div(f3);
    neg1   = rs1_is_signed(f3) & op1[WIDTH-1];
    neg2   = rs2_is_signed(f3) & op2[WIDTH-1];
    mag1   = neg1 ? -op1 : op1;
    mag2   = neg2 ? -op2 : op2;
    if (state == S_PREP) begin
      step_acc     = is_div ? {{(WIDTH+1){1'b0}}, mag1} : {{(WIDTH+1){1'b0}}, mag2};
      step_operand = is_div ? mag2 : mag1;
    end else begin
      step_acc     = acc;
      step_operand = operand_r;
    end
  end

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div),
    .acc      (step_acc),
    .operand  (step_operand),
    .next_acc (step_next)
  );

  // Sign correction and field selection for the final result
  always_comb begin
    prod_fix = neg_q ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
    quot_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    case (f3)
      MDU_MUL:                      fix_result = prod_fix[WIDTH-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: fix_result = prod_fix[2*WIDTH-1:WIDTH];
      MDU_DIV, MDU_DIVU:            fix_result = quot_fix;
      default:                      fix_result = rem_fix;
    endcase
  end

  // Sequencer FSM with registered busy/done/result
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      result_o  <= '0;
      cnt       <= '0;
      f3        <= '0;
      op1       <= '0;
      op2       <= '0;
      operand_r <= '0;
      acc       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            f3     <= funct3_i;
            op1    <= rs1_data_i;
            op2    <= rs2_data_i;
            busy_o <= 1'b1;
            state  <= S_PREP;
          end
        end
        S_PREP: begin
          neg_q     <= neg1 ^ neg2;
          neg_r     <= neg1;
          operand_r <= step_operand;
          cnt       <= CW'(WIDTH - 1);
          if (is_div && (op2 == '0)) begin
            // divide by zero: quotient all-ones, remainder the raw dividend
            result_o <= f3[1] ? op1 : '1;
            busy_o   <= 1'b0;
            done_o   <= 1'b1;
            state    <= S_DONE;
          end else begin
            acc   <= step_next;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          acc <= step_next;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          result_o <= fix_result;
          busy_o   <= 1'b0;
          done_o   <= 1'b1;
          state    <= S_DONE;
        end
        S_DONE: begin
          done_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb/tb_mdu_sequencer.sv - directed self-checking bench for mdu_sequencer
module tb_mdu_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_i;
  logic [2:0]   funct3_i;
  logic [W-1:0] rs1_data_i;
  logic [W-1:0] rs2_data_i;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] result_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  mdu_sequencer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start_i),
    .funct3_i   (funct3_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Drive one request in an IDLE cycle; returns at the negedge of cycle 2
  task automatic issue(input string tag, input logic [2:0] f3, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp, input bit push);
    @(negedge clk);
    check({tag, "_idle_busy"}, W'(busy_o), W'(0));
    check({tag, "_idle_done"}, W'(done_o), W'(0));
    start_i    = 1'b1;
    funct3_i   = f3;
    rs1_data_i = a;
    rs2_data_i = b;
    if (push) exp_q.push_back(exp);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Walk cycles from 2 on, checking busy/done timing and scoring the result
  task automatic wait_done(input string tag, input int exp_cycle, input bit perturb);
    bit found = 1'b0;
    logic [W-1:0] exp;
    for (int n = 2; n <= 60; n++) begin
      check($sformatf("%s_busy_c%0d", tag, n), W'(busy_o), W'(n < exp_cycle));
      check($sformatf("%s_done_c%0d", tag, n), W'(done_o), W'(n == exp_cycle));
      if (done_o) begin
        found = 1'b1;
        if (exp_q.size() == 0) begin
          check({tag, "_no_expectation"}, W'(1), W'(0));
        end else begin
          exp = exp_q.pop_front();
          check({tag, "_result"}, result_o, exp);
        end
        if (perturb) start_i = 1'b1;
        break;
      end
      if (perturb && n >= 3 && n <= 30) begin
        start_i    = n[0];
        funct3_i   = 3'($urandom_range(7));
        rs1_data_i = $urandom;
        rs2_data_i = $urandom;
      end
      @(negedge clk);
    end
    n_checks++;
    assert (found) else begin
      n_fail++;
      $error("FAIL %s_timeout observed=no_done expected=done_by_cycle_%0d", tag, exp_cycle);
    end
    if (perturb) begin
      @(negedge clk);
      start_i = 1'b0;
      check({tag, "_after_busy"}, W'(busy_o), W'(0));
      check({tag, "_after_done"}, W'(done_o), W'(0));
      @(negedge clk);
      check({tag, "_start_in_done_ignored"}, W'(busy_o), W'(0));
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input int exp_cycle);
    issue(tag, f3, a, b, exp, 1'b1);
    wait_done(tag, exp_cycle, 1'b0);
  endtask

  initial begin
    bit saw_done;
    reset      = 1'b1;
    start_i    = 1'b0;
    funct3_i   = 3'd0;
    rs1_data_i = '0;
    rs2_data_i = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", W'(busy_o), W'(0));
    check("reset_done", W'(done_o), W'(0));
    check("reset_result", result_o, '0);
    reset = 1'b0;

    run_op("mul_7_m3",      3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 35);
    run_op("mul_m1_m1",     3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 35);
    run_op("mulh_min_min",  3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 35);
    run_op("mulhu_max",     3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 35);
    run_op("mulhsu_max",    3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 35);
    run_op("div_m7_2",      3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 35);
    run_op("rem_m7_2",      3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 35);
    run_op("divu_7_2",      3'b101, 32'd7,        32'd2,        32'd3,        35);
    run_op("remu_7_2",      3'b111, 32'd7,        32'd2,        32'd1,        35);
    run_op("divu_5_0",      3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 3);
    run_op("remu_5_0",      3'b111, 32'd5,        32'd0,        32'd5,        3);
    run_op("div_m7_0",      3'b100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 3);
    run_op("rem_m7_0",      3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 3);
    run_op("div_ovf",       3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 35);
    run_op("rem_ovf",       3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 35);

    // start pulses and operand churn while busy, plus a start held into DONE
    issue("mul_perturb", 3'b000, 32'h00001234, 32'h00000010, 32'h00012340, 1'b1);
    wait_done("mul_perturb", 35, 1'b1);

    // reset in the middle of RUN aborts the operation without a done pulse
    issue("mul_abort", 3'b000, 32'd5, 32'd6, 32'd30, 1'b0);
    repeat (8) @(negedge clk);
    check("abort_running", W'(busy_o), W'(1));
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", W'(busy_o), W'(0));
    check("abort_done", W'(done_o), W'(0));
    check("abort_result", result_o, '0);
    reset = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_o || busy_o) saw_done = 1'b1;
    end
    check("abort_no_done", W'(saw_done), W'(0));

    run_op("mul_3_4", 3'b000, 32'd3, 32'd4, 32'd12, 35);

    check("scoreboard_empty", W'(exp_q.size()), W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
